// File: rtl/sd_cmd_sequencer.sv
// SPI-mode SD card command sequencer: power-up/init (CMD0, CMD8, CMD55/ACMD41), then CMD17 block reads.
// One byte exchange outstanding at a time; spi_start only issued while the SPI master is idle.
module sd_cmd_sequencer #(
    parameter int POWERUP_BYTES = 10,
    parameter int NCR_MAX       = 8,
    parameter int ACMD41_MAX    = 1000,
    parameter int TOKEN_MAX     = 4096,
    parameter int BLOCK_BYTES   = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_start,
    input  logic        read_start,
    input  logic [31:0] block_addr,
    output logic        card_ready,
    output logic        busy,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        done,
    output logic        error,
    output logic [2:0]  err_code,
    output logic        spi_start,
    output logic [7:0]  spi_tx,
    input  logic [7:0]  spi_rx,
    input  logic        spi_busy,
    input  logic        spi_new_data,
    output logic        ss,
    output logic        slow_sck
);

    localparam int PMAX = (TOKEN_MAX > NCR_MAX) ? TOKEN_MAX : NCR_MAX;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int IW   = $clog2(ACMD41_MAX + 1);

    localparam logic [9:0]    PWR_LAST   = 10'(POWERUP_BYTES - 1);
    localparam logic [9:0]    BLK_LAST   = 10'(BLOCK_BYTES - 1);
    localparam logic [PW-1:0] NCR_LAST   = PW'(NCR_MAX - 1);
    localparam logic [PW-1:0] TOK_LAST   = PW'(TOKEN_MAX - 1);
    localparam logic [IW-1:0] ACMD_LAST  = IW'(ACMD41_MAX - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PWRUP, S_CMD, S_R1, S_C8TAIL, S_GAP,
        S_READY, S_TOKEN, S_DATA, S_CRC, S_TRAIL, S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    cnt_q, cnt_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [IW-1:0] iter_q, iter_d;
    logic [5:0]    cmd_q, cmd_d;
    logic [31:0]   addr_q, addr_d;
    logic          wait_q, wait_d;
    logic          bad_q, bad_d;
    logic          fin_q, fin_d;
    logic          slow_q, slow_d;
    logic          done_q, done_d;
    logic [2:0]    err_q, err_d;

    logic          rx_ev;
    logic [31:0]   arg;
    logic [7:0]    crc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            poll_q  <= '0;
            iter_q  <= '0;
            cmd_q   <= '0;
            addr_q  <= '0;
            wait_q  <= 1'b0;
            bad_q   <= 1'b0;
            fin_q   <= 1'b0;
            slow_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            poll_q  <= poll_d;
            iter_q  <= iter_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wait_q  <= wait_d;
            bad_q   <= bad_d;
            fin_q   <= fin_d;
            slow_q  <= slow_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        poll_d  = poll_q;
        iter_d  = iter_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wait_d  = wait_q;
        bad_d   = bad_q;
        fin_d   = fin_q;
        slow_d  = slow_q;
        done_d  = 1'b0;
        err_d   = err_q;

        case (cmd_q)
            6'd8:    arg = 32'h0000_01AA;
            6'd41:   arg = 32'h4000_0000;
            6'd17:   arg = addr_q;
            default: arg = 32'h0;
        endcase
        case (cmd_q)
            6'd0:    crc = 8'h95;
            6'd8:    crc = 8'h87;
            default: crc = 8'h01;
        endcase

        busy       = !(state_q == S_IDLE || state_q == S_READY || state_q == S_ERROR);
        card_ready = (state_q == S_READY);
        error      = (state_q == S_ERROR);
        ss         = !(state_q == S_CMD || state_q == S_R1 || state_q == S_C8TAIL ||
                       state_q == S_TOKEN || state_q == S_DATA || state_q == S_CRC);

        // State and counters only move on spi_new_data, so spi_tx/ss hold for the whole exchange.
        rx_ev     = wait_q && spi_new_data;
        spi_start = busy && !wait_q && !spi_busy;
        if (spi_start) wait_d = 1'b1;
        if (rx_ev)     wait_d = 1'b0;

        spi_tx = 8'hFF;
        if (state_q == S_CMD) begin
            case (cnt_q)
                10'd0:   spi_tx = {2'b01, cmd_q};
                10'd1:   spi_tx = arg[31:24];
                10'd2:   spi_tx = arg[23:16];
                10'd3:   spi_tx = arg[15:8];
                10'd4:   spi_tx = arg[7:0];
                default: spi_tx = crc;
            endcase
        end

        data_valid = (state_q == S_DATA) && rx_ev;
        data_out   = data_valid ? spi_rx : 8'h00;

        case (state_q)
            S_IDLE: if (init_start) begin
                state_d = S_PWRUP;
                cnt_d   = '0;
                poll_d  = '0;
                iter_d  = '0;
                fin_d   = 1'b0;
                bad_d   = 1'b0;
                slow_d  = 1'b1;
            end
            S_PWRUP: if (rx_ev) begin
                if (cnt_q == PWR_LAST) begin
                    state_d = S_CMD;
                    cmd_d   = 6'd0;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 10'd1;
            end
            S_CMD: if (rx_ev) begin
                if (cnt_q == 10'd5) begin
                    state_d = S_R1;
                    poll_d  = '0;
                end else cnt_d = cnt_q + 10'd1;
            end
            S_R1: if (rx_ev) begin
                if (!spi_rx[7]) begin
                    state_d = S_GAP;
                    case (cmd_q)
                        6'd0: if (spi_rx == 8'h01) cmd_d = 6'd8;
                              else begin state_d = S_ERROR; err_d = 3'd1; end
                        6'd8: if (spi_rx == 8'h01) begin state_d = S_C8TAIL; cnt_d = '0; end
                              else begin state_d = S_ERROR; err_d = 3'd2; end
                        6'd55: cmd_d = 6'd41;
                        6'd41: if (spi_rx == 8'h00) fin_d = 1'b1;
                               else if (iter_q == ACMD_LAST) begin state_d = S_ERROR; err_d = 3'd3; end
                               else begin iter_d = iter_q + IW'(1); cmd_d = 6'd55; end
                        default: if (spi_rx == 8'h00) begin state_d = S_TOKEN; poll_d = '0; end
                                 else begin state_d = S_ERROR; err_d = 3'd6; end
                    endcase
                end else if (poll_q == NCR_LAST) begin
                    state_d = S_ERROR;
                    err_d   = 3'd4;
                end else poll_d = poll_q + PW'(1);
            end
            // Only the last two bytes of the R7 tail carry the voltage/check-pattern echo.
            S_C8TAIL: if (rx_ev) begin
                cnt_d = cnt_q + 10'd1;
                if (cnt_q == 10'd2) bad_d = (spi_rx != 8'h01);
                if (cnt_q == 10'd3) begin
                    if (bad_q || spi_rx != 8'hAA) begin state_d = S_ERROR; err_d = 3'd2; end
                    else begin state_d = S_GAP; cmd_d = 6'd55; end
                end
            end
            S_GAP: if (rx_ev) begin
                if (fin_q) begin
                    state_d = S_READY;
                    slow_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                end
            end
            S_READY: if (read_start) begin
                addr_d  = block_addr;
                cmd_d   = 6'd17;
                cnt_d   = '0;
                state_d = S_CMD;
            end
            S_TOKEN: if (rx_ev) begin
                if (spi_rx == 8'hFE) begin state_d = S_DATA; cnt_d = '0; end
                else if (spi_rx != 8'hFF || poll_q == TOK_LAST) begin state_d = S_ERROR; err_d = 3'd5; end
                else poll_d = poll_q + PW'(1);
            end
            S_DATA: if (rx_ev) begin
                if (cnt_q == BLK_LAST) begin state_d = S_CRC; cnt_d = '0; end
                else cnt_d = cnt_q + 10'd1;
            end
            S_CRC: if (rx_ev) begin
                if (cnt_q == 10'd1) state_d = S_TRAIL;
                else cnt_d = cnt_q + 10'd1;
            end
            S_TRAIL: if (rx_ev) begin
                state_d = S_READY;
                done_d  = 1'b1;
            end
            default: ;
        endcase
    end

    assign done     = done_q;
    assign err_code = err_q;
    assign slow_sck = slow_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Scoreboard bench for sd_cmd_sequencer with a behavioural SPI master and SD card model.
module tb_sd_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst, init_start, read_start;
    logic [31:0] block_addr;
    logic        card_ready, busy, data_valid, done, error, spi_start, ss, slow_sck;
    logic [7:0]  data_out, spi_tx, spi_rx;
    logic [2:0]  err_code;
    logic        spi_busy, spi_new_data;

    sd_cmd_sequencer dut (
        .clk(clk), .rst(rst), .init_start(init_start), .read_start(read_start),
        .block_addr(block_addr), .card_ready(card_ready), .busy(busy),
        .data_out(data_out), .data_valid(data_valid), .done(done), .error(error),
        .err_code(err_code), .spi_start(spi_start), .spi_tx(spi_tx), .spi_rx(spi_rx),
        .spi_busy(spi_busy), .spi_new_data(spi_new_data), .ss(ss), .slow_sck(slow_sck)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int data_cnt = 0;

    logic [8:0] exp_tx[$];
    logic [7:0] exp_data[$];

    // Card model state
    int         mode = 0;
    int         acmd_n = 0;
    int         fcnt = 0;
    logic [7:0] frame0;
    logic [7:0] reply_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic card_reset();
        reply_q.delete();
        fcnt = 0;
        acmd_n = 0;
    endtask

    task automatic card_respond(input logic [5:0] cmd);
        case (cmd)
            6'd0: if (mode != 2) begin reply_q.push_back(8'hFF); reply_q.push_back(8'h01); end
            6'd8: begin
                reply_q.push_back(8'hFF); reply_q.push_back(8'h01);
                reply_q.push_back(8'h00); reply_q.push_back(8'h00);
                reply_q.push_back(8'h01);
                reply_q.push_back((mode == 1) ? 8'hAB : 8'hAA);
            end
            6'd55: reply_q.push_back(8'h01);
            6'd41: begin
                reply_q.push_back((acmd_n < 2) ? 8'h01 : 8'h00);
                acmd_n++;
            end
            6'd17: begin
                reply_q.push_back(8'h00);
                if (mode != 3) begin
                    reply_q.push_back(8'hFF); reply_q.push_back(8'hFF); reply_q.push_back(8'hFF);
                    reply_q.push_back(8'hFE);
                    for (int i = 0; i < 512; i++) reply_q.push_back(i[7:0]);
                    reply_q.push_back(8'h5A); reply_q.push_back(8'hA5);
                end
            end
            default: ;
        endcase
    endtask

    task automatic card_xchg(input logic [7:0] tx, input logic s, output logic [7:0] rx);
        rx = 8'hFF;
        if (s) begin
            reply_q.delete();
            fcnt = 0;
        end else begin
            if (reply_q.size() > 0) rx = reply_q.pop_front();
            if (fcnt > 0 || (tx[7:6] == 2'b01 && reply_q.size() == 0)) begin
                if (fcnt == 0) frame0 = tx;
                fcnt++;
                if (fcnt == 6) begin
                    fcnt = 0;
                    card_respond(frame0[5:0]);
                end
            end
        end
    endtask

    // SPI master model: roughly six clocks per byte exchange.
    initial begin
        logic [7:0] r;
        spi_busy = 1'b0;
        spi_new_data = 1'b0;
        spi_rx = 8'h00;
        forever begin
            @(negedge clk);
            if (spi_start) begin
                card_xchg(spi_tx, ss, r);
                @(posedge clk); #1 spi_busy = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                spi_busy = 1'b0;
                spi_rx = r;
                spi_new_data = 1'b1;
                @(posedge clk); #1 spi_new_data = 1'b0;
            end
        end
    end

    // Monitor: pops expected exchanges and data bytes as the DUT presents them.
    initial begin
        logic [8:0] e;
        logic [7:0] d;
        forever begin
            @(negedge clk);
            if (spi_start) begin
                check("spi_start_idle_master", {31'b0, spi_busy}, 32'd0);
                if (exp_tx.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spi_xchg: got unexpected exchange ss=%0d tx=%02h, required none", ss, spi_tx);
                end else begin
                    e = exp_tx.pop_front();
                    check("spi_xchg {ss,tx}", {23'b0, ss, spi_tx}, {23'b0, e});
                end
            end
            if (data_valid) begin
                data_cnt++;
                if (exp_data.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL data_out: got unexpected byte %02h, required none", data_out);
                end else begin
                    d = exp_data.pop_front();
                    check("data_out", {24'b0, data_out}, {24'b0, d});
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic px(input logic s, input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) exp_tx.push_back({s, b});
    endtask

    task automatic pframe(input logic [7:0] b0, b1, b2, b3, b4, b5);
        px(0, b0, 1); px(0, b1, 1); px(0, b2, 1); px(0, b3, 1); px(0, b4, 1); px(0, b5, 1);
    endtask

    task automatic exp_pwr_cmd0_cmd8();
        px(1, 8'hFF, 10);
        pframe(8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95);
        px(0, 8'hFF, 2);
        px(1, 8'hFF, 1);
        pframe(8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87);
        px(0, 8'hFF, 6);
    endtask

    task automatic exp_init_ok();
        exp_pwr_cmd0_cmd8();
        px(1, 8'hFF, 1);
        for (int k = 0; k < 3; k++) begin
            pframe(8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
            px(0, 8'hFF, 1); px(1, 8'hFF, 1);
            pframe(8'h69, 8'h40, 8'h00, 8'h00, 8'h00, 8'h01);
            px(0, 8'hFF, 1); px(1, 8'hFF, 1);
        end
    endtask

    task automatic check_reset_vals();
        check("rst ss", {31'b0, ss}, 32'd1);
        check("rst slow_sck", {31'b0, slow_sck}, 32'd1);
        check("rst spi_start", {31'b0, spi_start}, 32'd0);
        check("rst spi_tx", {24'b0, spi_tx}, 32'hFF);
        check("rst done", {31'b0, done}, 32'd0);
        check("rst data_valid", {31'b0, data_valid}, 32'd0);
        check("rst error", {31'b0, error}, 32'd0);
        check("rst err_code", {29'b0, err_code}, 32'd0);
        check("rst card_ready", {31'b0, card_ready}, 32'd0);
        check("rst busy", {31'b0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check_reset_vals();
        repeat (10) @(negedge clk);
        card_reset();
        exp_tx.delete();
        exp_data.delete();
        done_cnt = 0;
        data_cnt = 0;
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic pulse_init();
        @(negedge clk) init_start = 1'b1;
        @(negedge clk) init_start = 1'b0;
    endtask

    task automatic pulse_read(input logic [31:0] a);
        @(negedge clk) begin read_start = 1'b1; block_addr = a; end
        @(negedge clk) begin read_start = 1'b0; block_addr = 32'hFFFF_FFFF; end
    endtask

    task automatic wait_cond(input int kind, input int limit, input string name);
        logic ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            case (kind)
                0: ok = card_ready;
                1: ok = (done_cnt >= 1);
                2: ok = error;
                default: ok = (data_cnt >= 200);
            endcase
            if (ok) break;
        end
        check(name, {31'b0, ok}, 32'd1);
    endtask

    task automatic run_init_ok();
        exp_init_ok();
        pulse_init();
        wait_cond(0, 5000, "init reaches READY");
        repeat (2) @(negedge clk);
        check("init done pulses", done_cnt, 32'd1);
        check("init slow_sck", {31'b0, slow_sck}, 32'd0);
        check("init card_ready", {31'b0, card_ready}, 32'd1);
        check("init exchanges left", exp_tx.size(), 32'd0);
    endtask

    task automatic exp_read_ok();
        pframe(8'h51, 8'h00, 8'h00, 8'h12, 8'h34, 8'h01);
        px(0, 8'hFF, 1 + 4 + 512 + 2);
        px(1, 8'hFF, 1);
        for (int i = 0; i < 512; i++) exp_data.push_back(i[7:0]);
    endtask

    initial begin
        rst = 1'b0; init_start = 1'b0; read_start = 1'b0; block_addr = 32'h0;
        do_reset();

        // read_start before init is ignored
        pulse_read(32'h0000_1234);
        repeat (20) @(negedge clk);
        check("early read busy", {31'b0, busy}, 32'd0);

        // Normal init then block read
        run_init_ok();
        pulse_init();
        repeat (20) @(negedge clk);
        check("late init ignored ready", {31'b0, card_ready}, 32'd1);
        done_cnt = 0;
        exp_read_ok();
        pulse_read(32'h0000_1234);
        wait_cond(1, 8000, "read completes");
        repeat (2) @(negedge clk);
        check("read data strobes", data_cnt, 32'd512);
        check("read done pulses", done_cnt, 32'd1);
        check("read ss end", {31'b0, ss}, 32'd1);
        check("read card_ready", {31'b0, card_ready}, 32'd1);
        check("read exchanges left", exp_tx.size(), 32'd0);

        // Reset mid-block, then full re-init
        data_cnt = 0;
        exp_read_ok();
        pulse_read(32'h0000_1234);
        wait_cond(3, 8000, "reach data byte 200");
        do_reset();
        run_init_ok();

        // CMD8 echo mismatch
        do_reset();
        mode = 1;
        exp_pwr_cmd0_cmd8();
        pulse_init();
        wait_cond(2, 5000, "cmd8 error");
        check("cmd8 err_code", {29'b0, err_code}, 32'd2);
        check("cmd8 ss", {31'b0, ss}, 32'd1);
        pulse_init();
        repeat (30) @(negedge clk);
        check("cmd8 error sticky", {31'b0, error}, 32'd1);
        check("cmd8 busy after init_start", {31'b0, busy}, 32'd0);
        check("cmd8 exchanges left", exp_tx.size(), 32'd0);

        // No R1 after CMD0
        do_reset();
        mode = 2;
        px(1, 8'hFF, 10);
        pframe(8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95);
        px(0, 8'hFF, 8);
        pulse_init();
        wait_cond(2, 5000, "r1 timeout error");
        repeat (20) @(negedge clk);
        check("r1 err_code", {29'b0, err_code}, 32'd4);
        check("r1 exchanges left", exp_tx.size(), 32'd0);

        // Data token never arrives
        do_reset();
        mode = 3;
        run_init_ok();
        pframe(8'h51, 8'h00, 8'h00, 8'h12, 8'h34, 8'h01);
        px(0, 8'hFF, 1 + 4096);
        pulse_read(32'h0000_1234);
        wait_cond(2, 40000, "token timeout error");
        repeat (20) @(negedge clk);
        check("token err_code", {29'b0, err_code}, 32'd5);
        check("token exchanges left", exp_tx.size(), 32'd0);
        check("token data strobes", data_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
